// File: rtl/grid_scan_driver.sv
// Row-multiplexed 8x8 LED scan driver with shadow/active double buffer and inter-row blanking.
// Latency: all outputs registered; a generation strobed in is displayed from the next frame boundary.
// Backpressure: none; gridValid strobes overwrite the shadow. Optional dimming via `GRID_SCAN_DIM_EN.
module grid_scan_driver #(
  parameter int DWELL_CYCLES   = 1000,
  parameter int BLANK_CYCLES   = 8,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] gridIn,
  input  logic        gridValid,
`ifdef GRID_SCAN_DIM_EN
  input  logic [3:0]  brightness,
`endif
  output logic [7:0]  rowSel,
  output logic [7:0]  colData,
  output logic        frameDone,
  output logic        gridPending
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [7:0] COL_OFF = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t         state, state_nxt;
  logic [2:0]     row, row_nxt;
  logic [BW-1:0]  blank_cnt, blank_cnt_nxt;
  logic [DW-1:0]  dwell_cnt, dwell_cnt_nxt;
  logic           frame_end;
  logic [63:0]    active, active_nxt;
  logic [63:0]    shadow, shadow_nxt;
  logic           pending_nxt;
  logic           lit;
  logic [7:0]     row_bits;
  logic [7:0]     col_nxt;
  logic [7:0]     row_sel_nxt;
`ifdef GRID_SCAN_DIM_EN
  logic [31:0]    lit_limit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BLANK;
      row       <= 3'd0;
      blank_cnt <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      blank_cnt <= blank_cnt_nxt;
      dwell_cnt <= dwell_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    blank_cnt_nxt = blank_cnt;
    dwell_cnt_nxt = dwell_cnt;
    frame_end     = 1'b0;
    unique case (state)
      BLANK: begin
        if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
          state_nxt     = DRIVE;
          blank_cnt_nxt = '0;
          dwell_cnt_nxt = '0;
        end else begin
          blank_cnt_nxt = blank_cnt + BW'(1);
        end
      end
      DRIVE: begin
        if (dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
          state_nxt     = BLANK;
          dwell_cnt_nxt = '0;
          blank_cnt_nxt = '0;
          row_nxt       = row + 3'd1;
          frame_end     = (row == 3'd7);
        end else begin
          dwell_cnt_nxt = dwell_cnt + DW'(1);
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Swap takes the shadow as it stood before this edge's strobe, so a
  // generation arriving on the swap edge stays pending for the next frame.
  always_comb begin
    active_nxt  = (frame_end && gridPending) ? shadow : active;
    shadow_nxt  = gridValid ? gridIn : shadow;
    pending_nxt = gridValid ? 1'b1 : ((frame_end && gridPending) ? 1'b0 : gridPending);
    row_bits    = active_nxt[{row_nxt, 3'b000} +: 8];
    lit         = (state_nxt == DRIVE);
`ifdef GRID_SCAN_DIM_EN
    lit_limit   = ((32'(brightness) + 32'd1) * 32'(DWELL_CYCLES)) >> 4;
    lit         = lit && (32'(dwell_cnt_nxt) < lit_limit);
`endif
    col_nxt     = lit ? (COL_ACTIVE_LOW ? ~row_bits : row_bits) : COL_OFF;
    row_sel_nxt = (state_nxt == DRIVE) ? (8'b1 << row_nxt) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rowSel      <= 8'h00;
      colData     <= COL_OFF;
      frameDone   <= 1'b0;
      gridPending <= 1'b0;
      active      <= '0;
      shadow      <= '0;
    end else begin
      rowSel      <= row_sel_nxt;
      colData     <= col_nxt;
      frameDone   <= frame_end;
      gridPending <= pending_nxt;
      active      <= active_nxt;
      shadow      <= shadow_nxt;
    end
  end

endmodule
